// File: rtl/magnetron_power_ctrl.sv
// magnetron_power_ctrl: run/pause/idle sequencer for a microwave magnetron.
// Provides slot-based duty-cycle power control, fan run-on after cooking,
// and cavity lamp control. The door interlock on mag_on is combinational,
// so the magnetron turns off without waiting for a clock edge.
module magnetron_power_ctrl #(
  parameter int PWR_W    = 3,
  parameter int SLOT_CYC = 100,
  parameter int FAN_HOLD = 500
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startN,
  input  logic             stopN,
  input  logic             clearN,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [PWR_W-1:0] power_lvl,
  output logic             mag_on,
  output logic             fan_on,
  output logic             lamp_on,
  output logic [1:0]       state,
  output logic             done
);

  localparam int MAX_LVL = (2 ** PWR_W) - 1;
  localparam int CNT_W   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int FAN_W   = $clog2(FAN_HOLD + 1);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [PWR_W-1:0] IDX_LAST  = PWR_W'(MAX_LVL - 1);
  localparam logic [FAN_W-1:0] FAN_LOAD  = FAN_W'(FAN_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COOK  = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_start_prev;
  logic [CNT_W-1:0] r_slot_cnt;
  logic [PWR_W-1:0] r_slot_idx;
  logic [PWR_W-1:0] r_lvl_q;
  logic             r_mag_q;
  logic [FAN_W-1:0] r_fan_cnt;
  logic             r_done;

  state_t           w_state_nxt;
  logic             w_start_evt;
  logic             w_enter_cook;
  logic             w_leave_cook;
  logic             w_slot_wrap;
  logic             w_frame_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PWR_W-1:0] w_idx_nxt;
  logic [PWR_W-1:0] w_lvl_nxt;
  logic             w_done_nxt;

  // A start event is a falling edge of startN, so holding the key gives one event.
  assign w_start_evt = r_start_prev & ~startN;

  // Next-state decision; clear beats timer, timer beats stop/door, those beat start.
  always_comb begin
    w_state_nxt = r_state;
    if (!clearN) begin
      w_state_nxt = ST_IDLE;
    end else if ((r_state == ST_COOK) && timer_done) begin
      w_state_nxt = ST_IDLE;
    end else if ((r_state == ST_COOK) && (!stopN || !door_closed)) begin
      w_state_nxt = ST_PAUSE;
    end else if ((r_state != ST_COOK) && w_start_evt && door_closed && stopN && !timer_done) begin
      w_state_nxt = ST_COOK;
    end
  end

  assign w_enter_cook = (r_state != ST_COOK) && (w_state_nxt == ST_COOK);
  assign w_leave_cook = (r_state == ST_COOK) && (w_state_nxt != ST_COOK);
  assign w_done_nxt   = (r_state == ST_COOK) && clearN && timer_done;

  assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_slot_wrap && (r_slot_idx == IDX_LAST);

  // Duty counters: restart on COOK entry, advance only while staying in COOK.
  always_comb begin
    w_cnt_nxt = r_slot_cnt;
    w_idx_nxt = r_slot_idx;
    w_lvl_nxt = r_lvl_q;
    if (w_enter_cook) begin
      w_cnt_nxt = '0;
      w_idx_nxt = '0;
      w_lvl_nxt = power_lvl;
    end else if ((r_state == ST_COOK) && (w_state_nxt == ST_COOK)) begin
      if (w_slot_wrap) begin
        w_cnt_nxt = '0;
        if (w_frame_wrap) begin
          w_idx_nxt = '0;
          w_lvl_nxt = power_lvl;
        end else begin
          w_idx_nxt = r_slot_idx + 1'b1;
        end
      end else begin
        w_cnt_nxt = r_slot_cnt + 1'b1;
      end
    end
  end

  // FSM state and registered control outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_IDLE;
      r_start_prev <= 1'b1;
      r_slot_cnt   <= '0;
      r_slot_idx   <= '0;
      r_lvl_q      <= '0;
      r_mag_q      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_prev <= startN;
      r_slot_cnt   <= w_cnt_nxt;
      r_slot_idx   <= w_idx_nxt;
      r_lvl_q      <= w_lvl_nxt;
      r_mag_q      <= (w_state_nxt == ST_COOK) && (w_idx_nxt < w_lvl_nxt);
      r_done       <= w_done_nxt;
    end
  end

  // Fan run-on counter: loaded on leaving COOK, counts down to zero outside COOK.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fan_cnt <= '0;
    end else if (w_leave_cook) begin
      r_fan_cnt <= FAN_LOAD;
    end else if (r_state == ST_COOK) begin
      r_fan_cnt <= '0;
    end else if (r_fan_cnt != '0) begin
      r_fan_cnt <= r_fan_cnt - 1'b1;
    end
  end

  // The door gate on the magnetron is deliberately combinational.
  assign mag_on  = r_mag_q & door_closed;
  assign fan_on  = (r_state == ST_COOK) || (r_fan_cnt != '0);
  assign lamp_on = resetN & ((r_state == ST_COOK) || !door_closed);
  assign state   = r_state;
  assign done    = r_done;

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Directed bench for magnetron_power_ctrl with SLOT_CYC=4, PWR_W=3, FAN_HOLD=10.
module tb_magnetron_power_ctrl;

  localparam int PWR_W    = 3;
  localparam int SLOT_CYC = 4;
  localparam int FAN_HOLD = 10;
  localparam int FRAME    = SLOT_CYC * 7;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_COOK  = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  logic             clk = 1'b0;
  logic             resetN;
  logic             startN;
  logic             stopN;
  logic             clearN;
  logic             door_closed;
  logic             timer_done;
  logic [PWR_W-1:0] power_lvl;
  logic             mag_on;
  logic             fan_on;
  logic             lamp_on;
  logic [1:0]       state;
  logic             done;

  int checks   = 0;
  int failures = 0;

  magnetron_power_ctrl #(
    .PWR_W   (PWR_W),
    .SLOT_CYC(SLOT_CYC),
    .FAN_HOLD(FAN_HOLD)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .startN     (startN),
    .stopN      (stopN),
    .clearN     (clearN),
    .door_closed(door_closed),
    .timer_done (timer_done),
    .power_lvl  (power_lvl),
    .mag_on     (mag_on),
    .fan_on     (fan_on),
    .lamp_on    (lamp_on),
    .state      (state),
    .done       (done)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetN      = 1'b0;
    startN      = 1'b1;
    stopN       = 1'b1;
    clearN      = 1'b1;
    door_closed = 1'b1;
    timer_done  = 1'b0;
    power_lvl   = 3'd3;
    #12;
    chk("rst_state", 8'(state), 8'(S_IDLE));
    chk("rst_mag",   8'(mag_on),  8'd0);
    chk("rst_fan",   8'(fan_on),  8'd0);
    chk("rst_lamp",  8'(lamp_on), 8'd0);
    chk("rst_done",  8'(done),    8'd0);
    resetN = 1'b1;
    step();
    step();
    chk("idle_state", 8'(state), 8'(S_IDLE));
    chk("idle_lamp",  8'(lamp_on), 8'd0);

    // 1: power 3 -> 12 cycles on, 16 off; startN held low after the edge
    startN = 1'b0;
    step();
    chk("t1_state", 8'(state), 8'(S_COOK));
    chk("t1_lamp",  8'(lamp_on), 8'd1);
    chk("t1_fan",   8'(fan_on),  8'd1);
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k > 0) step();
      chk("t1_duty", 8'(mag_on), 8'((k % FRAME) < 12));
    end
    chk("t1_hold_state", 8'(state), 8'(S_COOK));

    // 2: door opens in an ON slot
    step();
    chk("t2_mag_before", 8'(mag_on), 8'd1);
    door_closed = 1'b0;
    #1;
    chk("t2_mag_instant", 8'(mag_on), 8'd0);
    chk("t2_lamp",        8'(lamp_on), 8'd1);
    chk("t2_state_same",  8'(state), 8'(S_COOK));
    step();
    chk("t2_pause", 8'(state), 8'(S_PAUSE));
    chk("t2_fan",   8'(fan_on), 8'd1);
    chk("t2_lamp2", 8'(lamp_on), 8'd1);

    // 3: resume from PAUSE with a fresh start edge
    startN      = 1'b1;
    door_closed = 1'b1;
    step();
    chk("t3_still_pause", 8'(state), 8'(S_PAUSE));
    chk("t3_lamp_off",    8'(lamp_on), 8'd0);
    startN = 1'b0;
    step();
    chk("t3_cook", 8'(state), 8'(S_COOK));
    for (int k = 0; k < 14; k++) begin
      if (k > 0) step();
      chk("t3_duty_restart", 8'(mag_on), 8'(k < 12));
      chk("t3_fan",          8'(fan_on), 8'd1);
    end
    chk("t3_no_retrigger", 8'(state), 8'(S_COOK));

    // 4: timer_done and stop together -> IDLE with done, then fan run-on
    startN     = 1'b1;
    timer_done = 1'b1;
    stopN      = 1'b0;
    step();
    chk("t4_idle", 8'(state), 8'(S_IDLE));
    chk("t4_done", 8'(done),  8'd1);
    chk("t4_mag",  8'(mag_on), 8'd0);
    timer_done = 1'b0;
    stopN      = 1'b1;
    for (int j = 1; j <= FAN_HOLD + 1; j++) begin
      step();
      chk("t4_fan_runon", 8'(fan_on), 8'(j < FAN_HOLD));
      if (j == 1) chk("t4_done_once", 8'(done), 8'd0);
    end

    // 5a: clear beats timer_done
    startN = 1'b0;
    step();
    chk("t5_cook", 8'(state), 8'(S_COOK));
    startN     = 1'b1;
    clearN     = 1'b0;
    timer_done = 1'b1;
    step();
    chk("t5_clear_idle", 8'(state), 8'(S_IDLE));
    chk("t5_clear_done", 8'(done),  8'd0);
    step();
    chk("t5_clear_done2", 8'(done), 8'd0);
    clearN     = 1'b1;
    timer_done = 1'b0;

    // 5b: level 0 never turns on
    power_lvl = 3'd0;
    startN    = 1'b0;
    step();
    chk("t5_lvl0_cook", 8'(state), 8'(S_COOK));
    startN = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) step();
      chk("t5_lvl0_mag", 8'(mag_on), 8'd0);
    end

    // 5c: level 7 constant on; mid-frame change to 0 waits for the frame end
    stopN = 1'b0;
    step();
    chk("t5_pause", 8'(state), 8'(S_PAUSE));
    stopN     = 1'b1;
    power_lvl = 3'd7;
    startN    = 1'b0;
    step();
    chk("t5_lvl7_cook", 8'(state), 8'(S_COOK));
    startN = 1'b1;
    for (int k = 0; k < FRAME + 2; k++) begin
      if (k > 0) step();
      chk("t5_lvl7_mag", 8'(mag_on), 8'(k < FRAME));
      if (k == 5) power_lvl = 3'd0;
    end

    // 6: async reset mid-COOK while the magnetron is on
    clearN = 1'b0;
    step();
    clearN    = 1'b1;
    power_lvl = 3'd7;
    startN    = 1'b0;
    step();
    chk("t6_mag_on", 8'(mag_on), 8'd1);
    startN = 1'b1;
    #2;
    resetN = 1'b0;
    #1;
    chk("t6_mag",   8'(mag_on),  8'd0);
    chk("t6_fan",   8'(fan_on),  8'd0);
    chk("t6_lamp",  8'(lamp_on), 8'd0);
    chk("t6_state", 8'(state),   8'(S_IDLE));
    step();
    resetN = 1'b1;
    step();
    chk("t6_after_state", 8'(state),  8'(S_IDLE));
    chk("t6_after_fan",   8'(fan_on), 8'd0);

    // Start with door open is discarded, not queued
    door_closed = 1'b0;
    startN      = 1'b0;
    step();
    chk("dq_idle", 8'(state),   8'(S_IDLE));
    chk("dq_lamp", 8'(lamp_on), 8'd1);
    door_closed = 1'b1;
    step();
    step();
    chk("dq_not_queued", 8'(state), 8'(S_IDLE));
    chk("dq_mag",        8'(mag_on), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
